// File: rtl/serial_subtractor_4bit.sv
// Bit-serial ripple subtractor: d = a - b - bin, one bit per clock, LSB first,
// built from a single full-subtractor cell and a registered borrow.
module serial_subtractor_4bit #(
  parameter int WIDTH = 4,
  parameter int CW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-2:0] sh_d;
  logic             br;
  logic [CW-1:0]    cnt;

  logic             x;
  logic             y;
  logic             diff;
  logic             br_next;
  logic [WIDTH-1:0] acc;
  logic             last_bit;

  // Full-subtractor cell; acc is the difference collected so far including the
  // current bit, so on the final bit it is exactly the result.
  // NOTE: every always_comb output gets a value on every path, so no latch can be inferred.
  always_comb begin
    x        = sh_a[0];
    y        = sh_b[0];
    diff     = x ^ y ^ br;
    br_next  = (~x & y) | (~(x ^ y) & br);
    acc      = {diff, sh_d};
    last_bit = (cnt == CW'(WIDTH - 1));
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sh_a  <= '0;
      sh_b  <= '0;
      sh_d  <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      d     <= '0;
      bout  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            sh_a  <= a;
            sh_b  <= b;
            sh_d  <= '0;
            br    <= bin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= BUSY;
          end else begin
            state <= IDLE;
          end
        end

        BUSY: begin
          sh_a <= sh_a >> 1;
          sh_b <= sh_b >> 1;
          sh_d <= acc[WIDTH-1:1];
          br   <= br_next;
          cnt  <= cnt + CW'(1);
          if (last_bit) begin
            d     <= acc;
            bout  <= br_next;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor_4bit.sv
// Self-checking bench for serial_subtractor_4bit: directed vector table,
// back-to-back start, mid-operation reset and an exhaustive 4-bit sweep.
module tb_serial_subtractor_4bit;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             bout;

  int checks = 0;
  int errors = 0;

  serial_subtractor_4bit #(.WIDTH(WIDTH), .CW(3)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .bout  (bout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       bin;
    logic [3:0] exp_d;
    logic       exp_bout;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One full operation from IDLE: pulse start, then check latency, result,
  // no busy/done overlap, and that d/bout held the old result while busy.
  task automatic run_op(input logic [3:0] ta, input logic [3:0] tb_v, input logic tbin,
                        input logic [3:0] ed, input logic eb, input string tag);
    logic [3:0] prev_d;
    logic       prev_b;
    int         n;
    bit         stable;
    bit         overlap;
    @(posedge clk); #1;
    prev_d = d;
    prev_b = bout;
    a = ta; b = tb_v; bin = tbin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = ~ta; b = ~tb_v; bin = ~tbin;
    check({tag, " busy_after_start"}, 32'(busy), 32'd1);
    n = 0; stable = 1'b1; overlap = 1'b0;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (busy && done) overlap = 1'b1;
      if (!done && (d !== prev_d || bout !== prev_b)) stable = 1'b0;
    end
    check({tag, " latency"}, 32'(n), 32'(WIDTH));
    check({tag, " d"}, 32'(d), 32'(ed));
    check({tag, " bout"}, 32'(bout), 32'(eb));
    check({tag, " d_stable_while_busy"}, 32'(stable), 32'd1);
    check({tag, " busy_done_overlap"}, 32'(overlap), 32'd0);
    @(posedge clk); #1;
    check({tag, " done_one_cycle"}, 32'(done), 32'd0);
  endtask

  vec_t vecs[8];

  initial begin
    logic [4:0] ref5;
    int         done_cnt;
    bit         bad_done;

    vecs[0] = '{4'd5,  4'd3,  1'b0, 4'd2,  1'b0};
    vecs[1] = '{4'd3,  4'd5,  1'b0, 4'd14, 1'b1};
    vecs[2] = '{4'd0,  4'd0,  1'b1, 4'd15, 1'b1};
    vecs[3] = '{4'd15, 4'd15, 1'b0, 4'd0,  1'b0};
    vecs[4] = '{4'd8,  4'd7,  1'b1, 4'd0,  1'b0};
    vecs[5] = '{4'd10, 4'd3,  1'b1, 4'd6,  1'b0};
    vecs[6] = '{4'd0,  4'd15, 1'b1, 4'd0,  1'b1};
    vecs[7] = '{4'd2,  4'd9,  1'b0, 4'd9,  1'b1};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    #12;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset d", 32'(d), 32'd0);
    check("reset bout", 32'(bout), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 8; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].exp_d, vecs[i].exp_bout,
             $sformatf("vec%0d", i));

    // start held for 10 edges with operands changing every cycle: only the
    // k=0 set (first edge) and the k=5 set (DONE-cycle edge) are accepted.
    @(posedge clk); #1;
    done_cnt = 0;
    bad_done = 1'b0;
    start = 1'b1;
    for (int k = 0; k < 10; k++) begin
      a = 4'((3 * k + 7) & 15);
      b = 4'((5 * k + 2) & 15);
      bin = 1'(k & 1);
      @(posedge clk); #1;
      if (done) begin
        done_cnt++;
        if (k != 4 && k != 9) bad_done = 1'b1;
      end
      if (k == 4) begin
        check("b2b first done", 32'(done), 32'd1);
        check("b2b first d", 32'(d), 32'd5);
        check("b2b first bout", 32'(bout), 32'd0);
      end
      if (k == 9) begin
        check("b2b second done", 32'(done), 32'd1);
        check("b2b second d", 32'(d), 32'd10);
        check("b2b second bout", 32'(bout), 32'd1);
      end
    end
    start = 1'b0;
    check("b2b done count", 32'(done_cnt), 32'd2);
    check("b2b done timing", 32'(bad_done), 32'd0);
    @(posedge clk); #1;
    check("b2b back to idle busy", 32'(busy), 32'd0);
    check("b2b back to idle done", 32'(done), 32'd0);

    // Asynchronous reset during the second BUSY edge aborts the operation.
    @(posedge clk); #1;
    a = 4'd9; b = 4'd4; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("async rst busy", 32'(busy), 32'd0);
    check("async rst done", 32'(done), 32'd0);
    check("async rst d", 32'(d), 32'd0);
    check("async rst bout", 32'(bout), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bad_done = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (done || busy) bad_done = 1'b1;
    end
    check("no done after abort", 32'(bad_done), 32'd0);
    run_op(4'd9, 4'd4, 1'b0, 4'd5, 1'b0, "after_reset");

    // Exhaustive sweep against the unsigned mod-16 reference.
    for (int i = 0; i < 512; i++) begin
      logic [3:0] xa;
      logic [3:0] xb;
      logic       xc;
      xa = 4'(i >> 5);
      xb = 4'(i >> 1);
      xc = 1'(i);
      ref5 = {1'b0, xa} - {1'b0, xb} - {4'b0, xc};
      run_op(xa, xb, xc, ref5[3:0], ref5[4], $sformatf("ex a=%0d b=%0d bin=%0d", xa, xb, xc));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor_4bit.md
Name: serial_subtractor_4bit

Overview:
- Bit-serial ripple subtractor: the inverse arithmetic companion of the parallel full-adder datapath.
- Computes d = a - b - bin over WIDTH bits, one bit per clock, LSB first, using a single full-subtractor cell and a registered borrow.
- Operands are latched on a start pulse. A one-cycle done pulse marks the result; the result is then held until the next accepted start.
- Sits beside the parallel adder as the area-cheap subtract path and as a cross-check source for adder verification.

Parameters:
- WIDTH, 4, operand and result width in bits (legal range 2..16).
- CW, 3, bit counter width; must satisfy 2^CW > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- a  input  WIDTH  minuend; sampled on the accepting edge.
- b  input  WIDTH  subtrahend; sampled on the accepting edge.
- bin  input  1  borrow-in; sampled on the accepting edge.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse; result valid.
- d  output  WIDTH  difference, registered.
- bout  output  1  borrow-out, registered.

Behaviour:
- Reset: asynchronous, active-high. When rst=1: state=IDLE; busy=0, done=0, d=0, bout=0; internal shift registers, borrow flop and counter cleared. Reset asserted mid-operation aborts the operation; no done is produced.
- Registers: shift reg A, shift reg B, shift reg D, borrow flop br, bit counter cnt.
- States: IDLE, BUSY, DONE.
  - IDLE: if start=1 at edge E0: load A=a, B=b, br=bin, cnt=0, go to BUSY. busy=1 from after E0.
  - BUSY, each edge:
    - x=A[0], y=B[0].
    - diff = x^y^br.
    - br <= (~x&y) | (~(x^y)&br).
    - D <= {diff, D[WIDTH-1:1]}; A and B shift right by 1.
    - cnt <= cnt+1.
    - On the edge where cnt==WIDTH-1 (edge E_WIDTH): d <= final D (including this bit), bout <= new borrow, go to DONE, busy <= 0, done <= 1.
  - DONE: lasts exactly one cycle, with done=1. Next edge goes to IDLE and done <= 0. Exception: if start=1 at that edge, the new operation is accepted exactly as from IDLE (back-to-back, zero gap).
- Latency: start accepted at E0 → done high in the cycle after E_WIDTH, i.e. WIDTH+1 edges after start is sampled. Throughput is one result per WIDTH+1 cycles.
- start while BUSY is ignored. Operands are not re-sampled and no error is flagged.
- a, b and bin may change freely after the accepting edge; they do not affect the result.
- d and bout change only at E_WIDTH or on reset; they hold their last result through IDLE and through the next BUSY period.
- Arithmetic: d = (a - b - bin) mod 2^WIDTH. bout = 1 if and only if a < b + bin (unsigned). No signed overflow flag is produced.
- done and busy are never high in the same cycle.

Test Plan:
- Reset, then a=5, b=3, bin=0, start 1 cycle → busy for 4 cycles; done pulses 5 edges after start; d=2, bout=0.
- a=3, b=5, bin=0 → d=14 (4'b1110), bout=1. Then a=0, b=0, bin=1 → d=15, bout=1. Then a=15, b=15, bin=0 → d=0, bout=0.
- Start held high for 10 cycles with operands changing every cycle → only the first sample at E0 and a back-to-back sample in the DONE cycle are accepted. Results match those two sampled operand sets; done pulses twice, 5 cycles apart.
- Start a=9, b=4; assert rst at the 2nd BUSY edge for 1 cycle → busy, done, d and bout go to 0 immediately (asynchronously); no done follows; the next start a=9, b=4 gives d=5, bout=0.
- Exhaustive: all 512 combinations of a, b and bin run sequentially → every d and bout matches the mod-16 reference model; no done pulse is missing or extra; d is stable between done pulses.
